// File: rtl/fp_operand_align.sv
// Floating-point operand alignment ahead of an adder.
// Picks the larger-magnitude operand, then right-shifts the smaller mantissa
// over several cycles (SHIFT_STEP bits per cycle) while keeping a sticky bit.
// NaN/Inf operands bypass alignment and produce a ready-made result.

package floatingpointpkg;
    localparam int EXPBITS  = 8;
    localparam int FRACBITS = 23;

    typedef struct packed {
        logic                sign;
        logic [EXPBITS-1:0]  exp;
        logic [FRACBITS-1:0] frac;
    } float_t;
endpackage

// The module parameters must agree with the float_t layout in the package.
module fp_operand_align
    import floatingpointpkg::float_t;
#(
    parameter int EXPBITS    = 8,
    parameter int FRACBITS   = 23,
    parameter int SHIFT_STEP = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  float_t              a,
    input  float_t              b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sign_l,
    output logic                out_sign_s,
    output logic [EXPBITS-1:0]  out_exp,
    output logic [FRACBITS:0]   out_mant_l,
    output logic [FRACBITS+3:0] out_mant_s,
    output logic                out_swapped,
    output logic                out_special,
    output float_t              out_result
);

    localparam int MW = FRACBITS + 4;        // {hidden, frac, G, R, S}
    localparam int SW = $clog2(MW + 1);      // holds shift amounts 0..MW

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t state, state_nxt;
    logic   accept;
    logic [SW-1:0] rem;

    // Accept-time decode of the incoming pair
    logic          a_nan, b_nan, a_inf, b_inf;
    logic          acc_special, acc_swap;
    float_t        acc_result, op_l, op_s;
    logic [EXPBITS-1:0] exp_l, exp_s, diff;
    logic [SW-1:0] acc_shift;

    // Per-cycle shift step with sticky collection
    logic [SW-1:0] k;
    logic          lost;
    logic [MW-1:0] shifted;

    assign in_ready  = rst_n && (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    // Classify operands, select larger magnitude and compute clamped shift
    always_comb begin
        a_nan = (&a.exp) && (|a.frac);
        b_nan = (&b.exp) && (|b.frac);
        a_inf = (&a.exp) && !(|a.frac);
        b_inf = (&b.exp) && !(|b.frac);
        acc_special = a_nan || b_nan || a_inf || b_inf;

        // Opposite-signed infinities are invalid, like NaN inputs: quiet NaN
        if (a_nan || b_nan || (a_inf && b_inf && (a.sign != b.sign))) begin
            acc_result      = '0;
            acc_result.exp  = '1;
            acc_result.frac = {1'b1, {(FRACBITS-1){1'b0}}};
        end else if (a_inf) begin
            acc_result = a;
        end else begin
            acc_result = b;
        end

        // Ties keep a as the larger operand
        acc_swap = {b.exp, b.frac} > {a.exp, a.frac};
        op_l     = acc_swap ? b : a;
        op_s     = acc_swap ? a : b;
        exp_l    = (op_l.exp == '0) ? EXPBITS'(1) : op_l.exp;
        exp_s    = (op_s.exp == '0) ? EXPBITS'(1) : op_s.exp;
        diff     = exp_l - exp_s;
        // Beyond MW everything lands in the sticky bit anyway
        acc_shift = (int'(diff) > MW) ? SW'(MW) : SW'(diff);
    end

    // One SHIFT step: move right by k, OR all dropped bits into the LSB
    always_comb begin
        k          = (rem > SW'(SHIFT_STEP)) ? SW'(SHIFT_STEP) : rem;
        lost       = |(out_mant_s & ~({MW{1'b1}} << k));
        shifted    = out_mant_s >> k;
        shifted[0] = shifted[0] | lost;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = (acc_special || acc_shift == '0) ? DONE : SHIFT;
            SHIFT: if (rem <= SW'(SHIFT_STEP)) state_nxt = DONE;
            DONE:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load on accept, shift while in SHIFT, hold through DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sign_l  <= 1'b0;
            out_sign_s  <= 1'b0;
            out_exp     <= '0;
            out_mant_l  <= '0;
            out_mant_s  <= '0;
            out_swapped <= 1'b0;
            out_special <= 1'b0;
            out_result  <= '0;
            rem         <= '0;
        end else if (accept) begin
            out_sign_l  <= op_l.sign;
            out_sign_s  <= op_s.sign;
            out_exp     <= exp_l;
            out_mant_l  <= {(op_l.exp != '0), op_l.frac};
            out_mant_s  <= {(op_s.exp != '0), op_s.frac, 3'b000};
            out_swapped <= acc_swap;
            out_special <= acc_special;
            out_result  <= acc_result;
            rem         <= acc_special ? '0 : acc_shift;
        end else if (state == SHIFT) begin
            out_mant_s  <= shifted;
            rem         <= rem - k;
        end
    end

endmodule

// File: tb/tb_fp_operand_align.sv
// Directed bench for fp_operand_align with hand-computed expectations.
module tb_fp_operand_align;
    import floatingpointpkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    float_t        a = '0, b = '0;
    logic          in_ready, out_valid;
    logic          out_sign_l, out_sign_s, out_swapped, out_special;
    logic [7:0]    out_exp;
    logic [23:0]   out_mant_l;
    logic [26:0]   out_mant_s;
    float_t        out_result;

    int n_chk = 0;
    int n_pass = 0;
    int lat;
    logic [95:0] snap0, snap;
    logic seen;

    fp_operand_align #(.EXPBITS(8), .FRACBITS(23), .SHIFT_STEP(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out_sign_l(out_sign_l), .out_sign_s(out_sign_s), .out_exp(out_exp),
        .out_mant_l(out_mant_l), .out_mant_s(out_mant_s), .out_swapped(out_swapped),
        .out_special(out_special), .out_result(out_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Drive one pair, return edges from accept (inclusive) until out_valid
    task automatic send(input logic [31:0] va, input logic [31:0] vb, output int l);
        @(negedge clk);
        a = float_t'(va);
        b = float_t'(vb);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        l = 1;
        while (!out_valid && l < 64) begin
            @(posedge clk);
            #1 l++;
        end
        chk("out_valid", out_valid, 1'b1);
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic chk_norm(input string tag, input int l, input int el, input logic [7:0] e,
                            input logic [23:0] ml, input logic [26:0] ms,
                            input logic sw, input logic sl, input logic ss);
        chk({tag, ".lat"}, l, el);
        chk({tag, ".special"}, out_special, 1'b0);
        chk({tag, ".exp"}, out_exp, e);
        chk({tag, ".mant_l"}, out_mant_l, ml);
        chk({tag, ".mant_s"}, out_mant_s, ms);
        chk({tag, ".swapped"}, out_swapped, sw);
        chk({tag, ".sign_l"}, out_sign_l, sl);
        chk({tag, ".sign_s"}, out_sign_s, ss);
    endtask

    task automatic chk_byp(input string tag, input int l, input logic [31:0] r);
        chk({tag, ".lat"}, l, 1);
        chk({tag, ".special"}, out_special, 1'b1);
        chk({tag, ".result"}, out_result, r);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", in_ready, 1'b0);
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.mant_s", out_mant_s, '0);
        chk("rst.result", out_result, '0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("rel.in_ready", in_ready, 1'b1);

        // 1.0 vs 0.5: one-bit shift
        send(32'h3F800000, 32'h3F000000, lat);
        chk_norm("v1", lat, 2, 8'h7F, 24'h800000, 27'h2000000, 1'b0, 1'b0, 1'b0);
        consume();

        // 0.5 vs -1.0: b larger
        send(32'h3F000000, 32'hBF800000, lat);
        chk_norm("v2", lat, 2, 8'h7F, 24'h800000, 27'h2000000, 1'b1, 1'b1, 1'b0);
        consume();

        // diff 30 clamps to 27; everything collapses into sticky
        send(32'h3F800000, 32'h30800000, lat);
        chk_norm("v3", lat, 8, 8'h7F, 24'h800000, 27'h0000001, 1'b0, 1'b0, 1'b0);
        consume();

        // s=4 with a one dropped -> sticky set
        send(32'h3F800000, 32'h3DC00001, lat);
        chk_norm("v4", lat, 2, 8'h7F, 24'h800000, 27'h0600001, 1'b0, 1'b0, 1'b0);
        consume();

        // s=5 spans two shift cycles
        send(32'h3F800000, 32'h3D400001, lat);
        chk_norm("v5", lat, 3, 8'h7F, 24'h800000, 27'h0300001, 1'b0, 1'b0, 1'b0);
        consume();

        // Equal magnitude tie keeps a as larger, no shift
        send(32'h40000000, 32'hC0000000, lat);
        chk_norm("tie", lat, 1, 8'h80, 24'h800000, 27'h4000000, 1'b0, 1'b0, 1'b1);
        consume();

        // Zeros take the normal path
        send(32'h00000000, 32'h00000000, lat);
        chk_norm("zero", lat, 1, 8'h01, 24'h000000, 27'h0000000, 1'b0, 1'b0, 1'b0);
        consume();

        // Smallest normal vs smallest denormal: both effective exp 1
        send(32'h00800000, 32'h00000001, lat);
        chk_norm("denorm", lat, 1, 8'h01, 24'h800000, 27'h0000008, 1'b0, 1'b0, 1'b0);
        consume();

        // Bypass cases
        send(32'h7FC00001, 32'h3F800000, lat);
        chk_byp("nan", lat, 32'h7FC00000);
        consume();
        send(32'h7F800000, 32'hFF800000, lat);
        chk_byp("inf_inf", lat, 32'h7FC00000);
        consume();
        send(32'h7F800000, 32'h3F800000, lat);
        chk_byp("pinf", lat, 32'h7F800000);
        consume();
        send(32'h3F800000, 32'hFF800000, lat);
        chk_byp("ninf", lat, 32'hFF800000);
        consume();

        // Backpressure: hold DONE for 5 cycles
        send(32'h3F800000, 32'h3F000000, lat);
        snap0 = {in_ready, out_sign_l, out_sign_s, out_exp, out_mant_l, out_mant_s,
                 out_swapped, out_special, out_result};
        repeat (5) begin
            @(posedge clk);
            #1;
            snap = {in_ready, out_sign_l, out_sign_s, out_exp, out_mant_l, out_mant_s,
                    out_swapped, out_special, out_result};
            chk("hold.stable", snap == snap0, 1'b1);
            chk("hold.in_ready", in_ready, 1'b0);
            chk("hold.out_valid", out_valid, 1'b1);
        end
        consume();
        chk("release.in_ready", in_ready, 1'b1);
        chk("release.out_valid", out_valid, 1'b0);
        send(32'h3F000000, 32'hBF800000, lat);
        chk_norm("b2b", lat, 2, 8'h7F, 24'h800000, 27'h2000000, 1'b1, 1'b1, 1'b0);
        consume();

        // Reset in the middle of a long shift
        @(negedge clk);
        a = float_t'(32'h3F800000);
        b = float_t'(32'h30800000);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("mid.out_valid", out_valid, 1'b0);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("arst.out_valid", out_valid, 1'b0);
        chk("arst.in_ready", in_ready, 1'b0);
        chk("arst.mant_s", out_mant_s, '0);
        chk("arst.mant_l", out_mant_l, '0);
        chk("arst.exp", out_exp, '0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("arst.rel.in_ready", in_ready, 1'b1);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1 if (out_valid) seen = 1'b1;
        end
        chk("arst.no_stale", seen, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fp_operand_align.md
FP_OPERAND_ALIGN -- requirements
Module: fp_operand_align

Interface
REQ-001 Parameters SHALL be:
- EXPBITS, 8, exponent width.
- FRACBITS, 23, fraction width.
- SHIFT_STEP, 4, maximum right-shift bits per SHIFT cycle (1..FRACBITS+4).
REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- a, b  in  float_t each  operands, float_t from floatingpointpkg.
- out_valid  out  1  aligned result valid.
- out_ready  in  1  downstream adder accepts the result.
- out_sign_l, out_sign_s  out  1 each  signs of the larger- and smaller-magnitude operands.
- out_exp  out  EXPBITS  effective exponent of the larger operand.
- out_mant_l  out  FRACBITS+1  larger mantissa including hidden bit.
- out_mant_s  out  FRACBITS+4  smaller mantissa: {hidden, frac, G, R, S}, after the shift.
- out_swapped  out  1  b was selected as the larger operand.
- out_special  out  1  special-case bypass; only out_result is meaningful.
- out_result  out  float_t  bypass result.
REQ-003 Clock and reset SHALL be clk and rst_n: one clock, asynchronous active-low reset.

Function
REQ-004 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-005 in_ready SHALL be 1 only in IDLE with rst_n high; in_ready SHALL NOT depend combinationally on out_ready.
REQ-006 A transfer SHALL occur on an edge where in_valid && in_ready; a and b SHALL be sampled on that edge.
REQ-007 Special-case bypass on accept:
- Either operand NaN, or +Inf with -Inf -> out_special=1, out_result=32'h7FC00000.
- Otherwise, either operand Inf -> out_special=1, out_result = that Inf (sign preserved).
- In both cases, next state DONE.
REQ-008 Normal operands:
- Effective exponent = exp, or 1 if denormal/zero.
- Hidden bit = 1, or 0 if denormal/zero.
- The larger operand is the one with larger {exp,frac}; on a tie, a is larger and out_swapped=0.
REQ-009 Shift amount s SHALL be min(exp_l_eff - exp_s_eff, FRACBITS+4). out_mant_s SHALL start as {hidden_s, frac_s, 3'b000}.
REQ-010 On accept, s=0 SHALL go to DONE; otherwise to SHIFT.
REQ-011 Each SHIFT cycle SHALL shift right by k = min(remaining, SHIFT_STEP) bits.
- S (LSB) = S OR every bit shifted out.
- remaining decrements by k; when remaining reaches 0, go to DONE.
REQ-012 Latency from accept edge to out_valid SHALL be 1 + ceil(s/SHIFT_STEP) cycles; bypass latency SHALL be 1.
REQ-013 In DONE, out_valid SHALL be 1; all outputs SHALL hold stable until the edge with out_ready=1, after which state returns to IDLE.
REQ-014 When s = FRACBITS+4, out_mant_s SHALL equal 1 if the original smaller mantissa is nonzero, and 0 otherwise.
REQ-015 Zero operands SHALL take the normal path, not the bypass.
REQ-016 Outputs other than out_valid and in_ready SHALL be don't-care outside DONE, but SHALL be registered (no combinational path from a, b).

Reset
REQ-017 While rst_n=0: state IDLE; out_valid, in_ready and all data outputs 0.
REQ-018 After rst_n deasserts, in_ready SHALL be 1 from the first cycle.
REQ-019 Reset asserted mid-SHIFT or in DONE SHALL discard the transaction immediately; no stale out_valid SHALL appear after release.

Verification
REQ-020 Bench SHALL cover these scenarios (SHIFT_STEP=4):
- a=3F800000, b=3F000000 -> after 2 cycles: out_exp=7F, out_mant_l=800000, out_mant_s=27'h2000000, out_swapped=0, out_special=0.
- a=3F000000, b=BF800000 -> out_swapped=1, out_sign_l=1, out_sign_s=0, out_mant_s=27'h2000000.
- a=3F800000, b=30800000 (diff 30, s=27) -> out_mant_s=27'h0000001, latency 8 cycles.
- a=7FC00001, b=3F800000 -> out_special=1, out_result=7FC00000, latency 1; a=7F800000, b=FF800000 -> 7FC00000; a=7F800000, b=3F800000 -> 7F800000.
- Hold out_ready=0 for 5 cycles in DONE -> outputs bit-stable, in_ready=0; out_ready=1 -> in_ready=1 next cycle, back-to-back second pair accepted.
- Assert rst_n=0 during SHIFT -> outputs 0 asynchronously; after release, in_ready=1 and no out_valid without a new transfer.
